// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - beat/phase timing generator with console run control and cycle counter
module beat_sequencer #(
    parameter int PHASES = 3,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic             STEP_MODE,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic [2:0]       W,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             RUN,
    output logic [CNT_W-1:0] CYC_CNT
);

    localparam int             PH_W    = (PHASES > 2) ? $clog2(PHASES) : 2;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nx;
    logic            cnt_inc;
    logic            eoc;
    logic            ph_last;

    logic            start_s1;
    logic            start_s2;
    logic            start_s2_d;
    logic            start_edge;

    // START synchronizer plus registered rising-edge pulse
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_s2_d <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_s1   <= START;
            start_s2   <= start_s1;
            start_s2_d <= start_s2;
            start_edge <= start_s2 & ~start_s2_d;
        end
    end

    // State, phase counter and completed-cycle counter
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state   <= HALT;
            ph      <= '0;
            CYC_CNT <= '0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
            if (cnt_inc) begin
                CYC_CNT <= CYC_CNT + 1'b1;
            end
        end
    end

    // Next-state decision at the last phase of each beat, and beat/phase decode
    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        cnt_inc  = 1'b0;
        eoc      = 1'b0;
        ph_last  = (ph == PH_LAST);
        RUN      = 1'b0;
        W        = 3'b001;
        T1       = 1'b0;
        T2       = 1'b0;
        T3       = 1'b0;

        case (state)
            HALT: begin
                ph_nx = '0;
                if (start_edge) begin
                    state_nx = B1;
                end
            end
            default: begin
                RUN = 1'b1;
                if (!ph_last) begin
                    ph_nx = ph + 1'b1;
                end else begin
                    ph_nx = '0;
                    case (state)
                        B1:      eoc = SHORT;
                        B2:      eoc = ~LONG;
                        default: eoc = 1'b1;
                    endcase
                    if (STOP) begin
                        // forced end of cycle: still counts as a completed cycle
                        cnt_inc  = 1'b1;
                        state_nx = HALT;
                    end else if (eoc) begin
                        cnt_inc  = 1'b1;
                        state_nx = STEP_MODE ? HALT : B1;
                    end else begin
                        state_nx = (state == B1) ? B2 : B3;
                    end
                end
            end
        endcase

        case (state)
            B2:      W = 3'b010;
            B3:      W = 3'b100;
            default: W = 3'b001;
        endcase

        if (RUN) begin
            T1 = (ph == '0);
            T3 = ph_last;
            T2 = (ph != '0) && !ph_last;
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - randomized and directed checks of beat_sequencer against a behavioural model
module tb_beat_sequencer;

    localparam int PHASES = 3;
    localparam int CNT_W  = 8;

    logic             CLK       = 1'b0;
    logic             CLR       = 1'b0;
    logic             START     = 1'b0;
    logic             STEP_MODE = 1'b0;
    logic             SHORT     = 1'b0;
    logic             LONG      = 1'b0;
    logic             STOP      = 1'b0;
    logic [2:0]       W;
    logic             T1;
    logic             T2;
    logic             T3;
    logic             RUN;
    logic [CNT_W-1:0] CYC_CNT;

    int compared   = 0;
    int mismatched = 0;

    beat_sequencer #(.PHASES(PHASES), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .START     (START),
        .STEP_MODE (STEP_MODE),
        .SHORT     (SHORT),
        .LONG      (LONG),
        .STOP      (STOP),
        .W         (W),
        .T1        (T1),
        .T2        (T2),
        .T3        (T3),
        .RUN       (RUN),
        .CYC_CNT   (CYC_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: beat number (0 = halted), phase within beat, cycle count,
    // and START history (hist[0] = most recent clock's sample).
    int m_beat = 0;
    int m_ph   = 0;
    int m_cnt  = 0;
    int hist [4] = '{0, 0, 0, 0};
    int edge_seen;
    int end_cyc;
    int exp_w;
    int exp_run;

    always @(posedge CLK) begin
        if (!CLR) begin
            m_beat = 0;
            m_ph   = 0;
            m_cnt  = 0;
            for (int i = 0; i < 4; i++) hist[i] = 0;
        end else begin
            // a START rise is acted on three clocks after it is first sampled
            edge_seen = (hist[2] == 1 && hist[3] == 0) ? 1 : 0;
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = START ? 1 : 0;
            if (m_beat == 0) begin
                if (edge_seen == 1) begin
                    m_beat = 1;
                    m_ph   = 0;
                end
            end else if (m_ph < PHASES - 1) begin
                m_ph = m_ph + 1;
            end else begin
                m_ph = 0;
                end_cyc = (STOP || (m_beat == 1 && SHORT) || (m_beat == 2 && !LONG) || m_beat == 3) ? 1 : 0;
                if (end_cyc == 1) begin
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    m_beat = (STOP || STEP_MODE) ? 0 : 1;
                end else begin
                    m_beat = m_beat + 1;
                end
            end
        end
        #1;
        exp_run = (m_beat != 0) ? 1 : 0;
        exp_w   = (m_beat == 0) ? 1 : (1 << (m_beat - 1));
        chk("model_W", W, exp_w);
        chk("model_RUN", RUN, exp_run);
        chk("model_T1", T1, (exp_run == 1 && m_ph == 0) ? 1 : 0);
        chk("model_T2", T2, (exp_run == 1 && m_ph > 0 && m_ph < PHASES - 1) ? 1 : 0);
        chk("model_T3", T3, (exp_run == 1 && m_ph == PHASES - 1) ? 1 : 0);
        chk("model_CYC_CNT", CYC_CNT, m_cnt);
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Wait (bounded) until beat w is showing phase pulse t (1..3)
    task automatic wait_for(input logic [2:0] w, input int t, input string name);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 40) begin
            step();
            n++;
            hit = (W == w) && ((t == 1 && T1) || (t == 2 && T2) || (t == 3 && T3));
        end
        if (!hit) chk(name, 0, 1);
    endtask

    int k;
    int c;
    int n_run;
    int wexp [3] = '{1, 2, 4};

    initial begin
        // reset
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        step();
        chk("reset_W", W, 1);
        chk("reset_RUN", RUN, 0);
        chk("reset_T1", T1, 0);
        chk("reset_CYC_CNT", CYC_CNT, 0);

        // SHORT always: one-beat cycles, START latency, counter wrap
        SHORT = 1'b1;
        START = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!T1 && k < 10);
        chk("start_latency", k, 4);
        START = 1'b0;
        chk("short_W", W, 1);
        repeat (765) @(posedge CLK);
        #2;
        chk("short_cnt_255", CYC_CNT, 255);
        chk("short_T1_again", T1, 1);
        repeat (3) @(posedge CLK);
        #2;
        chk("short_cnt_wrap", CYC_CNT, 0);

        // LONG: three-beat cycle
        SHORT = 1'b0;
        LONG  = 1'b1;
        wait_for(3'b001, 1, "long_sync");
        c = m_cnt;
        for (int i = 0; i < 9; i++) begin
            chk("long_W_seq", W, wexp[i / 3]);
            step();
        end
        chk("long_W_back", W, 1);
        chk("long_cnt", CYC_CNT, (c + 1) % 256);

        // STOP at T3 of B2, START held high does not restart
        LONG  = 1'b0;
        START = 1'b1;
        wait_for(3'b010, 3, "stop_sync");
        STOP = 1'b1;
        c = m_cnt;
        step();
        STOP = 1'b0;
        chk("stop_RUN", RUN, 0);
        chk("stop_W", W, 1);
        chk("stop_cnt", CYC_CNT, (c + 1) % 256);
        repeat (10) step();
        chk("held_no_restart", RUN, 0);
        START = 1'b0;
        repeat (4) step();
        START = 1'b1;
        wait_for(3'b001, 1, "resume_sync");
        chk("resume_RUN", RUN, 1);
        START = 1'b0;

        // single-step mode: one nine-clock cycle per press
        STEP_MODE = 1'b1;
        LONG      = 1'b1;
        k = 0;
        while (RUN && k < 40) begin
            step();
            k++;
        end
        chk("step_halted", RUN, 0);
        for (int p = 0; p < 2; p++) begin
            c = m_cnt;
            START = 1'b1;
            repeat (2) step();
            START = 1'b0;
            n_run = 0;
            repeat (30) begin
                step();
                if (RUN) n_run++;
            end
            chk("step_run_clks", n_run, 9);
            chk("step_cnt", CYC_CNT, (c + 1) % 256);
        end

        // reset in the middle of B2
        STEP_MODE = 1'b0;
        START     = 1'b1;
        wait_for(3'b010, 2, "midreset_sync");
        START = 1'b0;
        #1;
        CLR = 1'b0;
        #1;
        chk("midreset_W", W, 1);
        chk("midreset_T2", T2, 0);
        chk("midreset_RUN", RUN, 0);
        chk("midreset_CYC_CNT", CYC_CNT, 0);
        step();
        chk("midreset_no_T3", T3, 0);
        @(negedge CLK);
        CLR = 1'b1;

        // randomized traffic checked by the model every clock
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            SHORT = 1'($urandom_range(0, 1));
            LONG  = 1'($urandom_range(0, 1));
            STOP  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) START = ~START;
            if ($urandom_range(0, 49) == 0) STEP_MODE = ~STEP_MODE;
            CLR = ($urandom_range(0, 499) != 0);
        end
        @(negedge CLK);
        CLR = 1'b1;
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
